myproject_infer_ctrl: RTL and testbench

//  Sequencer between a valid/ready sample stream and the hls4ml myproject core (ap_ctrl_hs, ap_vld I/O).

---
 rtl/myproject_infer_ctrl.sv | 128 ++++++++++++
 tb/tb_myproject_infer_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_infer_ctrl.sv
// Sequencer between a valid/ready sample stream and the hls4ml myproject core (ap_ctrl_hs).
// Optional perf counters (lat_last, inf_count) are enabled by defining PERF_COUNTERS_EN.
module myproject_infer_ctrl #(
   parameter int IN_W    = 48,
   parameter int OUT_W   = 16,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic [IN_W-1:0]  s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [OUT_W-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             core_start,
   output logic [IN_W-1:0]  core_in,
   output logic             core_in_vld,
   input  logic             core_done,
   input  logic             core_ready,
   input  logic             core_idle,
   input  logic [OUT_W-1:0] core_out,
   input  logic             core_out_vld,
   output logic             busy,
   output logic             timeout_err,
   input  logic             err_clr
`ifdef PERF_COUNTERS_EN
  ,output logic [CNT_W-1:0] lat_last,
   output logic [CNT_W-1:0] inf_count
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic             got_vld;
   logic [CNT_W-1:0] wdog;

   assign s_ready = (state == IDLE) & core_idle;
   assign busy    = (state != IDLE);

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state       <= IDLE;
         got_vld     <= 1'b0;
         wdog        <= '0;
         core_start  <= 1'b0;
         core_in_vld <= 1'b0;
         core_in     <= '0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         timeout_err <= 1'b0;
`ifdef PERF_COUNTERS_EN
         lat_last    <= '0;
         inf_count   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (s_valid && s_ready) begin
                  core_in     <= s_data;
                  core_start  <= 1'b1;
                  core_in_vld <= 1'b1;
                  wdog        <= '0;
                  got_vld     <= 1'b0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               wdog <= wdog + 1'b1;
               // Completion in the last allowed cycle beats the watchdog.
               if (core_ready && (core_done || core_out_vld)) begin
                  m_data      <= core_out;
                  m_valid     <= 1'b1;
                  core_start  <= 1'b0;
                  core_in_vld <= 1'b0;
                  state       <= HOLD;
`ifdef PERF_COUNTERS_EN
                  lat_last    <= wdog + 1'b1;
`endif
               end else if (wdog == WD_LAST) begin
                  timeout_err <= 1'b1;
                  core_start  <= 1'b0;
                  core_in_vld <= 1'b0;
                  state       <= IDLE;
               end else if (core_ready) begin
                  core_start  <= 1'b0;
                  core_in_vld <= 1'b0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               wdog <= wdog + 1'b1;
               if (core_out_vld && !got_vld) begin
                  m_data  <= core_out;
                  got_vld <= 1'b1;
               end
               if (core_done) begin
                  if (!got_vld) m_data <= core_out;
                  m_valid <= 1'b1;
                  state   <= HOLD;
`ifdef PERF_COUNTERS_EN
                  lat_last <= wdog + 1'b1;
`endif
               end else if (wdog == WD_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= IDLE;
`ifdef PERF_COUNTERS_EN
                  inf_count <= inf_count + 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
         if (err_clr) timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_myproject_infer_ctrl.sv
// Directed bench for myproject_infer_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_myproject_infer_ctrl;

   logic        ap_clk, ap_rst;
   logic [47:0] s_data;
   logic        s_valid, s_ready;
   logic [15:0] m_data;
   logic        m_valid, m_ready;
   logic        core_start, core_in_vld;
   logic [47:0] core_in;
   logic        core_done, core_ready, core_idle, core_out_vld;
   logic [15:0] core_out;
   logic        busy, timeout_err, err_clr;
`ifdef PERF_COUNTERS_EN
   logic [31:0] lat_last, inf_count;
`endif

   int checks = 0;
   int failures = 0;

   myproject_infer_ctrl #(.IN_W(48), .OUT_W(16), .TIMEOUT(16), .CNT_W(32)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .core_start(core_start), .core_in(core_in), .core_in_vld(core_in_vld),
      .core_done(core_done), .core_ready(core_ready), .core_idle(core_idle),
      .core_out(core_out), .core_out_vld(core_out_vld),
      .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
`ifdef PERF_COUNTERS_EN
     ,.lat_last(lat_last), .inf_count(inf_count)
`endif
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   // Called at a falling edge; returns at the next falling edge with the DUT in ISSUE.
   task automatic start_inf(input logic [47:0] d);
      s_data = d; s_valid = 1'b1; core_idle = 1'b1;
      @(negedge ap_clk);
      s_valid = 1'b0;
   endtask

   task automatic clear_core();
      core_done = 1'b0; core_out_vld = 1'b0; core_ready = 1'b0; core_out = 16'h0000;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1; core_idle = 1'b0; s_valid = 1'b0; s_data = '0;
      m_ready = 1'b0; err_clr = 1'b0; clear_core();
      #12;
      checks++;
      if ({core_start, core_in_vld, m_valid, busy, timeout_err, s_ready} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {core_start, core_in_vld, m_valid, busy, timeout_err, s_ready});
      end
      checks++;
      if (core_in !== 48'h0 || m_data !== 16'h0) begin
         failures++; $display("FAIL reset_data core_in=%h m_data=%h exp=0", core_in, m_data);
      end
`ifdef PERF_COUNTERS_EN
      checks++;
      if (lat_last !== 32'd0 || inf_count !== 32'd0) begin
         failures++; $display("FAIL reset_perf lat=%0d cnt=%0d exp=0", lat_last, inf_count);
      end
`endif
      @(negedge ap_clk);
      ap_rst = 1'b0; core_idle = 1'b1;
      @(negedge ap_clk);
   endtask

   task automatic test_basic();
      int sr_hi = 0;
      int mv_early = 0;
      checks++;
      if (s_ready !== 1'b1) begin
         failures++; $display("FAIL basic_idle_ready got=%b exp=1", s_ready);
      end
      start_inf(48'h0001_0002_0003);
      checks++;
      if (core_start !== 1'b1 || core_in_vld !== 1'b1 || core_in !== 48'h0001_0002_0003) begin
         failures++;
         $display("FAIL basic_issue start=%b vld=%b in=%h exp=1 1 000100020003",
                  core_start, core_in_vld, core_in);
      end
      core_idle = 1'b0; core_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge ap_clk);
         core_ready = 1'b0;
         if (s_ready !== 1'b0) sr_hi++;
         if (m_valid !== 1'b0 || core_start !== 1'b0) mv_early++;
         if (k == 5) begin core_done = 1'b1; core_out_vld = 1'b1; core_out = 16'h00A5; end
      end
      @(negedge ap_clk);
      clear_core(); core_idle = 1'b1;
      if (s_ready !== 1'b0) sr_hi++;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h00A5) begin
         failures++; $display("FAIL basic_result valid=%b data=%h exp=1 00a5", m_valid, m_data);
      end
      checks++;
      if (mv_early != 0) begin
         failures++; $display("FAIL basic_wait_outputs bad_cycles=%0d exp=0", mv_early);
      end
      m_ready = 1'b1;
      @(negedge ap_clk);
      m_ready = 1'b0;
      checks++;
      if (sr_hi != 0) begin
         failures++; $display("FAIL basic_sready_low high_cycles=%0d exp=0", sr_hi);
      end
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_return valid=%b busy=%b s_ready=%b exp=0 0 1", m_valid, busy, s_ready);
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      start_inf(48'hAAAA_BBBB_CCCC);
      core_ready = 1'b1; core_idle = 1'b0;
      @(negedge ap_clk);
      core_ready = 1'b0; core_done = 1'b1; core_out_vld = 1'b1; core_out = 16'h1234;
      @(negedge ap_clk);
      clear_core(); core_out = 16'hFFFF; core_idle = 1'b1;
      s_valid = 1'b1; s_data = 48'h1111_2222_3333;
      for (int i = 0; i < 10; i++) begin
         if (m_valid !== 1'b1 || m_data !== 16'h1234 || s_ready !== 1'b0 || core_start !== 1'b0)
            bad++;
         @(negedge ap_clk);
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL bp_hold_stable bad_cycles=%0d exp=0", bad);
      end
      m_ready = 1'b1; s_valid = 1'b0;
      @(negedge ap_clk);
      m_ready = 1'b0; core_out = 16'h0000;
      checks++;
      if (m_valid !== 1'b0 || core_in !== 48'hAAAA_BBBB_CCCC || busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_no_accept valid=%b core_in=%h busy=%b exp=0 aaaabbbbcccc 0",
                  m_valid, core_in, busy);
      end
   endtask

   task automatic test_capture();
      start_inf(48'h0000_0000_0010);
      core_ready = 1'b1; core_idle = 1'b0;
      @(negedge ap_clk);
      core_ready = 1'b0; core_out_vld = 1'b1; core_out = 16'h1111;
      @(negedge ap_clk);
      core_out = 16'h2222;
      @(negedge ap_clk);
      core_out_vld = 1'b0; core_done = 1'b1; core_out = 16'h3333;
      @(negedge ap_clk);
      clear_core(); core_idle = 1'b1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h1111) begin
         failures++; $display("FAIL cap_first_vld valid=%b data=%h exp=1 1111", m_valid, m_data);
      end
      m_ready = 1'b1;
      @(negedge ap_clk);
      m_ready = 1'b0;
      start_inf(48'h0000_0000_0020);
      core_ready = 1'b1; core_idle = 1'b0;
      @(negedge ap_clk);
      core_ready = 1'b0; core_done = 1'b1; core_out = 16'h4444;
      @(negedge ap_clk);
      clear_core(); core_idle = 1'b1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h4444) begin
         failures++; $display("FAIL cap_done_no_vld valid=%b data=%h exp=1 4444", m_valid, m_data);
      end
      m_ready = 1'b1;
      @(negedge ap_clk);
      m_ready = 1'b0;
   endtask

   task automatic test_zero_latency();
      start_inf(48'h0000_0000_0030);
      core_ready = 1'b1; core_done = 1'b1; core_out_vld = 1'b1; core_out = 16'h0C3C;
      @(negedge ap_clk);
      clear_core();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h0C3C || core_start !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL zl_direct_hold valid=%b data=%h start=%b busy=%b exp=1 0c3c 0 1",
                  m_valid, m_data, core_start, busy);
      end
      m_ready = 1'b1;
      @(negedge ap_clk);
      m_ready = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL zl_return valid=%b busy=%b exp=0 0", m_valid, busy);
      end
   endtask

   task automatic test_timeout();
      int mv = 0;
      start_inf(48'h0000_0000_0040);
      core_idle = 1'b0;
      // Core never raises ready: DUT sits in ISSUE for 16 cycles (negedges 1..16).
      for (int k = 1; k < 16; k++) begin
         if (m_valid !== 1'b0) mv++;
         @(negedge ap_clk);
      end
      checks++;
      if (core_start !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL to_last_cycle start=%b busy=%b err=%b exp=1 1 0", core_start, busy, timeout_err);
      end
      @(negedge ap_clk);
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0 || mv != 0 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL to_abort err=%b busy=%b start=%b valid=%b exp=1 0 0 0",
                  timeout_err, busy, core_start, m_valid);
      end
      core_done = 1'b1; core_out_vld = 1'b1; core_out = 16'hDEAD;
      @(negedge ap_clk);
      clear_core(); err_clr = 1'b1;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL to_late_done valid=%b busy=%b exp=0 0", m_valid, busy);
      end
      @(negedge ap_clk);
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++; $display("FAIL to_err_clr got=%b exp=0", timeout_err);
      end
      start_inf(48'h0000_0000_0050);
      core_ready = 1'b1; core_idle = 1'b0;
      @(negedge ap_clk);
      core_ready = 1'b0; core_done = 1'b1; core_out_vld = 1'b1; core_out = 16'h5A5A;
      @(negedge ap_clk);
      clear_core(); core_idle = 1'b1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h5A5A || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL to_recover valid=%b data=%h err=%b exp=1 5a5a 0", m_valid, m_data, timeout_err);
      end
      m_ready = 1'b1;
      @(negedge ap_clk);
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      start_inf(48'h0000_0000_0060);
      core_ready = 1'b1; core_idle = 1'b0;
      @(negedge ap_clk);
      core_ready = 1'b0;
      @(negedge ap_clk);
      ap_rst = 1'b1;
      #1;
      checks++;
      if ({core_start, core_in_vld, m_valid, busy, timeout_err, s_ready} !== 6'b0 ||
          core_in !== 48'h0 || m_data !== 16'h0) begin
         failures++;
         $display("FAIL rst_async flags=%b core_in=%h m_data=%h exp=0",
                  {core_start, core_in_vld, m_valid, busy, timeout_err, s_ready}, core_in, m_data);
      end
      @(negedge ap_clk);
      ap_rst = 1'b0;
      core_done = 1'b1; core_out_vld = 1'b1; core_out = 16'h0077;
      @(negedge ap_clk);
      clear_core(); core_idle = 1'b1;
      @(negedge ap_clk);
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 16'h0) begin
         failures++;
         $display("FAIL rst_late_done valid=%b busy=%b data=%h exp=0 0 0000", m_valid, busy, m_data);
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      int sr_bad = 0;
      logic [15:0] exp_d;
      for (int i = 0; i < 3; i++) begin
         if (s_ready !== 1'b1) sr_bad++;
         start_inf(48'(i + 1));
         core_ready = 1'b1; core_idle = 1'b0;
         for (int k = 1; k <= 7; k++) begin
            @(negedge ap_clk);
            core_ready = 1'b0;
            if (k == 7) begin core_done = 1'b1; core_out_vld = 1'b1; core_out = 16'h0100 + 16'(i); end
         end
         @(negedge ap_clk);
         clear_core(); core_idle = 1'b1;
         exp_d = 16'h0100 + 16'(i);
         if (m_valid !== 1'b1 || m_data !== exp_d || s_ready !== 1'b0) bad++;
         m_ready = 1'b1;
         @(negedge ap_clk);
         m_ready = 1'b0;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL b2b_results bad=%0d exp=0", bad);
      end
      checks++;
      if (sr_bad != 0 || s_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_sready bad=%0d s_ready=%b exp=0 1", sr_bad, s_ready);
      end
`ifdef PERF_COUNTERS_EN
      checks++;
      if (inf_count !== 32'd3) begin
         failures++; $display("FAIL b2b_inf_count got=%0d exp=3", inf_count);
      end
      checks++;
      if (lat_last !== 32'd8) begin
         failures++; $display("FAIL b2b_lat_last got=%0d exp=8", lat_last);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_capture();
      test_zero_latency();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
